// File: rtl/key_schedule_engine_if.sv
// key_schedule_engine_if
//   Groups the control and round-key read signals of key_schedule_engine.
//   Parameter KEY_BITS sets the key_in width (128/192/256).
//   Optional macro STREAM_OUT_EN adds the round-key stream outputs.
//
//   start         master->slave  begin expansion (taken only while idle)
//   key_in        master->slave  cipher key, word 0 in the top 32 bits
//   rk_idx        master->slave  round-key read index
//   busy          slave->master  expansion in progress
//   done          slave->master  one-cycle pulse, last word written
//   keys_valid    slave->master  whole schedule valid
//   rk_out        slave->master  combinational round-key read data
//   dbg_state     slave->master  FSM state (0 = IDLE, 1 = EXPAND)
//   rk_stream_*   slave->master  (STREAM_OUT_EN) streamed round keys
//
// Handshake: start is sampled on each rising edge; it is accepted only when
// the engine is idle (busy=0) and is silently dropped otherwise. There is no
// back-pressure: once accepted, the engine raises busy on the next cycle,
// drops it together with a one-cycle done pulse, and keys_valid holds from
// that point until the next accepted start.
interface key_schedule_engine_if #(
   parameter int KEY_BITS = 128
);
   logic                start;
   logic [KEY_BITS-1:0] key_in;
   logic [3:0]          rk_idx;
   logic                busy;
   logic                done;
   logic                keys_valid;
   logic [127:0]        rk_out;
   logic                dbg_state;
`ifdef STREAM_OUT_EN
   logic                rk_stream_valid;
   logic [127:0]        rk_stream;
   logic [3:0]          rk_stream_idx;

   modport master (
      output start, key_in, rk_idx,
      input  busy, done, keys_valid, rk_out, dbg_state,
      input  rk_stream_valid, rk_stream, rk_stream_idx
   );
   modport slave (
      input  start, key_in, rk_idx,
      output busy, done, keys_valid, rk_out, dbg_state,
      output rk_stream_valid, rk_stream, rk_stream_idx
   );
`else
   modport master (
      output start, key_in, rk_idx,
      input  busy, done, keys_valid, rk_out, dbg_state
   );
   modport slave (
      input  start, key_in, rk_idx,
      output busy, done, keys_valid, rk_out, dbg_state
   );
`endif
endinterface

// File: rtl/key_schedule_engine.sv
// key_schedule_engine
//   Iterative AES key expander for 128/192/256-bit keys. Loads the cipher
//   key into a word file, then produces one schedule word per clock until
//   all 4*(NR+1) words exist. Round keys are read by index, combinationally.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    key_schedule_engine_if.slave (start/key_in/rk_idx in;
//            busy/done/keys_valid/rk_out/dbg_state out)
//
//   Optional macro STREAM_OUT_EN: also streams each round key out the cycle
//   after it is complete (rk_stream_valid/rk_stream/rk_stream_idx).
module key_schedule_engine #(
   parameter int KEY_BITS = 128
) (
   input  logic                 clk,
   input  logic                 reset,
   key_schedule_engine_if.slave bus
);
   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);

   if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
      $error("key_schedule_engine: KEY_BITS must be 128, 192 or 256");
   end

   typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [5:0]  i_q, i_d;          // index of the next word to write
   logic [2:0]  j_q, j_d;          // i modulo NK, kept as a counter
   logic [7:0]  rcon_q, rcon_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        kv_q, kv_d;
   logic [31:0] w_q [NW];
   logic [31:0] w_d [NW];
   logic [31:0] prev_w, far_w, temp_w, new_w;
   logic [5:0]  rk_base;
`ifdef STREAM_OUT_EN
   logic         sv_q, sv_d;
   logic [127:0] sk_q, sk_d;
   logic [3:0]   sidx_q, sidx_d;
`endif

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int n = 0; n < 8; n++) begin
         if (b[n]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box as multiplicative inverse (x^254, so 0 maps to 0) plus affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, b;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      x252 = gf_mul(x240, x12);
      b    = gf_mul(x252, x2);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      rcon_d  = rcon_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      kv_d    = kv_q;
      w_d     = w_q;
      prev_w  = 32'h0;
      far_w   = 32'h0;
      temp_w  = 32'h0;
      new_w   = 32'h0;
`ifdef STREAM_OUT_EN
      sv_d    = 1'b0;
      sk_d    = sk_q;
      sidx_d  = sidx_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               for (int k = 0; k < NK; k++) begin
                  w_d[k] = bus.key_in[KEY_BITS-1-32*k -: 32];
               end
               i_d     = 6'(NK);
               j_d     = 3'd0;
               rcon_d  = 8'h01;
               kv_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = EXPAND;
`ifdef STREAM_OUT_EN
               // Round key 0 always lies wholly inside the cipher key.
               sv_d   = 1'b1;
               sidx_d = 4'd0;
               sk_d   = {w_d[0], w_d[1], w_d[2], w_d[3]};
`endif
            end
         end
         EXPAND: begin
            prev_w = w_q[i_q - 6'd1];
            far_w  = w_q[i_q - 6'(NK)];
            temp_w = prev_w;
            if (j_q == 3'd0) begin
               temp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h0};
               rcon_d = xtime(rcon_q);
            end else if (NK == 8 && j_q == 3'd4) begin
               temp_w = sub_word(prev_w);
            end
            new_w      = far_w ^ temp_w;
            w_d[i_q]   = new_w;
            i_d        = i_q + 6'd1;
            j_d        = (j_q == 3'(NK - 1)) ? 3'd0 : j_q + 3'd1;
`ifdef STREAM_OUT_EN
            if (i_q[1:0] == 2'b11) begin
               sv_d   = 1'b1;
               sidx_d = i_q[5:2];
               sk_d   = {w_q[i_q - 6'd3], w_q[i_q - 6'd2], w_q[i_q - 6'd1], new_w};
            end else if (NK == 8 && i_q == 6'd8) begin
               // 256-bit keys also hold round key 1; emit it on the first step.
               sv_d   = 1'b1;
               sidx_d = 4'd1;
               sk_d   = {w_q[4], w_q[5], w_q[6], w_q[7]};
            end
`endif
            if (i_q == 6'(NW - 1)) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               kv_d    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         i_q     <= 6'd0;
         j_q     <= 3'd0;
         rcon_q  <= 8'h01;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         kv_q    <= 1'b0;
         for (int k = 0; k < NW; k++) w_q[k] <= 32'h0;
`ifdef STREAM_OUT_EN
         sv_q    <= 1'b0;
         sk_q    <= 128'h0;
         sidx_q  <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         rcon_q  <= rcon_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         kv_q    <= kv_d;
         w_q     <= w_d;
`ifdef STREAM_OUT_EN
         sv_q    <= sv_d;
         sk_q    <= sk_d;
         sidx_q  <= sidx_d;
`endif
      end
   end

   // Indices above NR read as zero rather than aliasing into the word file.
   always_comb begin
      rk_base    = {bus.rk_idx, 2'b00};
      bus.rk_out = 128'h0;
      if (bus.rk_idx <= 4'(NR)) begin
         bus.rk_out = {w_q[rk_base], w_q[rk_base + 6'd1],
                       w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.keys_valid = kv_q;
   assign bus.dbg_state  = state_q;
`ifdef STREAM_OUT_EN
   assign bus.rk_stream_valid = sv_q;
   assign bus.rk_stream       = sk_q;
   assign bus.rk_stream_idx   = sidx_q;
`endif
endmodule
